// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a producer-side FIFO feeding a serialiser with
// 5..8 data bits, optional even/odd parity, 1 or 2 stop bits and a runtime bit divisor.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_en,
  output logic                 wr_ready,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 ovf_clr,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 fifo_empty,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  state_t               state_next;
  logic [DIV_W-1:0]     tick;
  logic [DIV_W-1:0]     tick_next;
  logic [BW-1:0]        bit_idx;
  logic [BW-1:0]        bit_next;
  logic                 stop_idx;
  logic                 stop_next;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shift_next;
  logic [DIV_W-1:0]     div_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop2_q;
  logic [DIV_W-1:0]     eff_div;
  logic [DIV_W-1:0]     reload;
  logic                 txd_next;
  logic                 done_next;

  assign head       = mem[rd_ptr];
  assign push       = wr_en && wr_ready;
  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign eff_div    = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign reload     = div_q - DIV_W'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // A write attempted while full is dropped and flags overflow, even if a pop
  // frees a slot in the same cycle, because acceptance follows the registered wr_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      wr_ready <= (count_next != CNT_W'(FIFO_DEPTH));
      if (wr_en && !wr_ready) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    tick_next  = tick;
    bit_next   = bit_idx;
    stop_next  = stop_idx;
    shift_next = shreg;
    pop        = 1'b0;
    txd_next   = 1'b1;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
          tick_next  = eff_div - DIV_W'(1);
        end
      end
      START: begin
        txd_next = 1'b0;
        if (tick == '0) begin
          state_next = DATA;
          tick_next  = reload;
          bit_next   = '0;
        end else begin
          tick_next = tick - DIV_W'(1);
        end
      end
      DATA: begin
        txd_next = shreg[0];
        if (tick == '0) begin
          tick_next  = reload;
          shift_next = shreg >> 1;
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            state_next = par_en_q ? PARITY : STOP;
            stop_next  = 1'b0;
          end else begin
            bit_next = bit_idx + BW'(1);
          end
        end else begin
          tick_next = tick - DIV_W'(1);
        end
      end
      PARITY: begin
        txd_next = par_bit_q;
        if (tick == '0) begin
          state_next = STOP;
          stop_next  = 1'b0;
          tick_next  = reload;
        end else begin
          tick_next = tick - DIV_W'(1);
        end
      end
      STOP: begin
        txd_next = 1'b1;
        if (tick == '0) begin
          if (stop2_q && !stop_idx) begin
            stop_next = 1'b1;
            tick_next = reload;
          end else begin
            done_next = 1'b1;
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (!fifo_empty) begin
              pop        = 1'b1;
              state_next = START;
              tick_next  = eff_div - DIV_W'(1);
            end else begin
              state_next = IDLE;
            end
          end
        end else begin
          tick_next = tick - DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the current state, so txd follows the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      div_q      <= DIV_W'(2);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      tick       <= tick_next;
      bit_idx    <= bit_next;
      stop_idx   <= stop_next;
      txd        <= txd_next;
      tx_busy    <= (state != IDLE);
      frame_done <= done_next;
      if (pop) begin
        shreg     <= head;
        div_q     <= eff_div;
        par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_q <= (^head) ^ (parity_mode == 2'b10);
        stop2_q   <= stop2;
      end else begin
        shreg <= shift_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame table, hand-written corner sequences
// and randomized batches checked against a queue-based frame model.
module tb_uart_tx_fifo;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int CW    = 5;

  logic          clk;
  logic          rst;
  logic [DB-1:0] wr_data;
  logic          wr_en;
  logic          wr_ready;
  logic [DW-1:0] baud_div;
  logic [1:0]    parity_mode;
  logic          stop2;
  logic          ovf_clr;
  logic          txd;
  logic          tx_busy;
  logic          frame_done;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  uart_tx_fifo #(
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DW),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .ovf_clr     (ovf_clr),
    .txd         (txd),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [15:0] div;
    logic [1:0]  pm;
    logic        s2;
    logic [7:0]  data;
    int          exp_len;
    logic        chk_par;
    logic        exp_par;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    wr_data = data;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int frame_len(input int div, input logic [1:0] pm, input logic s2);
    int p;
    p = (pm == 2'b01 || pm == 2'b10) ? 1 : 0;
    return (1 + DB + p + (s2 ? 2 : 1)) * div;
  endfunction

  // Waits for a start bit, then compares txd and frame_done on every cycle of the
  // frame against the bit sequence the frame format dictates.
  task automatic check_frame(input logic [7:0] data, input int div, input logic [1:0] pm,
                             input logic s2, output int meas_len, output int start_wait,
                             output logic par_seen);
    logic lv[$];
    int   len;
    int   bad;
    int   dbad;
    int   first_bad;
    int   t;
    lv = {};
    lv.push_back(1'b0);
    for (int i = 0; i < DB; i++) lv.push_back(data[i]);
    if (pm == 2'b01) lv.push_back(^data);
    if (pm == 2'b10) lv.push_back(~^data);
    lv.push_back(1'b1);
    if (s2) lv.push_back(1'b1);
    len      = lv.size() * div;
    meas_len = 0;
    par_seen = 1'bx;
    t = 0;
    while (txd !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    start_wait = t;
    if (txd !== 1'b0) begin
      tests++;
      fails++;
      $display("[TB] FAIL start_timeout: no start bit for data %02h", data);
      return;
    end
    bad = 0;
    dbad = 0;
    first_bad = -1;
    for (int k = 0; k < len; k++) begin
      if (txd !== lv[k / div]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (frame_done === 1'b1 && meas_len == 0) meas_len = k + 1;
      if (frame_done !== (k == len - 1)) dbad++;
      if (k == (1 + DB) * div + div / 2) par_seen = txd;
      @(negedge clk);
    end
    checkOutput($sformatf("frame_%02h_txd_bad_cycles(first=%0d)", data, first_bad), bad, 0);
    checkOutput($sformatf("frame_%02h_done_bad_cycles", data), dbad, 0);
  endtask

  int          mlen;
  int          swait;
  logic        par;
  int          bad;
  int          t;
  logic [7:0]  q[$];
  int          rdiv;
  logic [1:0]  rpm;
  logic        rs2;
  int          rn;
  logic [7:0]  pd;
  logic [7:0]  cd;

  initial begin
    vecs[0] = '{16'd4, 2'b00, 1'b0, 8'h55, 40, 1'b0, 1'b0};
    vecs[1] = '{16'd4, 2'b01, 1'b0, 8'h07, 44, 1'b1, 1'b1};
    vecs[2] = '{16'd4, 2'b10, 1'b0, 8'h07, 44, 1'b1, 1'b0};
    vecs[3] = '{16'd4, 2'b00, 1'b1, 8'hA3, 44, 1'b0, 1'b0};
    vecs[4] = '{16'd0, 2'b00, 1'b0, 8'h5A, 20, 1'b0, 1'b0};
    vecs[5] = '{16'd1, 2'b01, 1'b1, 8'hFF, 24, 1'b1, 1'b0};
    vecs[6] = '{16'd3, 2'b11, 1'b0, 8'h80, 30, 1'b0, 1'b0};
    vecs[7] = '{16'd5, 2'b10, 1'b1, 8'h00, 60, 1'b1, 1'b1};

    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    baud_div = 16'd4;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_busy", tx_busy, 0);
    checkOutput("reset_done", frame_done, 0);
    checkOutput("reset_count", fifo_count, 0);
    checkOutput("reset_empty", fifo_empty, 1);
    checkOutput("reset_wr_ready", wr_ready, 1);
    checkOutput("reset_overflow", overflow, 0);

    // Basic 8N1 with start-bit latency: write at edge N, txd low from edge N+2.
    applyStimulus(8'h55);
    checkOutput("latency_n1_txd", txd, 1);
    @(negedge clk);
    checkOutput("latency_n2_txd", txd, 1);
    @(negedge clk);
    checkOutput("latency_n3_txd", txd, 0);
    check_frame(8'h55, 4, 2'b00, 1'b0, mlen, swait, par);
    checkOutput("basic_len", mlen, 40);
    checkOutput("basic_busy_after", tx_busy, 0);

    for (int i = 0; i < 8; i++) begin
      baud_div    = vecs[i].div;
      parity_mode = vecs[i].pm;
      stop2       = vecs[i].s2;
      applyStimulus(vecs[i].data);
      check_frame(vecs[i].data, eff_div(int'(vecs[i].div)), vecs[i].pm, vecs[i].s2,
                  mlen, swait, par);
      checkOutput($sformatf("vec%0d_len", i), mlen, vecs[i].exp_len);
      if (vecs[i].chk_par) checkOutput($sformatf("vec%0d_parity", i), par, vecs[i].exp_par);
      checkOutput($sformatf("vec%0d_busy_after", i), tx_busy, 0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames with two stop bits.
    baud_div = 16'd4;
    parity_mode = 2'b00;
    stop2 = 1'b1;
    wr_data = 8'hA3;
    wr_en = 1'b1;
    @(negedge clk);
    wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    check_frame(8'hA3, 4, 2'b00, 1'b1, mlen, swait, par);
    checkOutput("b2b_len1", mlen, 44);
    check_frame(8'h3C, 4, 2'b00, 1'b1, mlen, swait, par);
    checkOutput("b2b_len2", mlen, 44);
    checkOutput("b2b_gap", swait, 0);
    stop2 = 1'b0;
    repeat (3) @(negedge clk);

    // FIFO full, dropped write, overflow set-wins and clear, exactly five frames.
    baud_div = 16'd100;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          wr_data = 8'(i);
          wr_en = 1'b1;
          @(negedge clk);
        end
        wr_en = 1'b0;
        checkOutput("full_count", fifo_count, 4);
        checkOutput("full_wr_ready", wr_ready, 0);
        checkOutput("full_overflow", overflow, 1);
        wr_data = 8'h77;
        wr_en = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        ovf_clr = 1'b0;
        checkOutput("ovf_set_wins", overflow, 1);
        checkOutput("full_count_after_drop", fifo_count, 4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", overflow, 0);
      end
      begin
        for (int i = 1; i <= 5; i++) begin
          check_frame(8'(i), 100, 2'b00, 1'b0, mlen, swait, par);
          checkOutput($sformatf("full_frame%0d_len", i), mlen, 1000);
        end
      end
    join
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (txd !== 1'b1) bad++;
      @(negedge clk);
    end
    checkOutput("no_sixth_frame", bad, 0);
    checkOutput("full_drained_empty", fifo_empty, 1);

    // Reset in the middle of the data bits with bytes still queued.
    baud_div = 16'd4;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'hC0 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    t = 0;
    while (txd !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_txd", txd, 1);
    checkOutput("midrst_count", fifo_count, 0);
    checkOutput("midrst_done", frame_done, 0);
    checkOutput("midrst_busy", tx_busy, 0);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (txd !== 1'b1 || frame_done !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput("midrst_quiet", bad, 0);
    applyStimulus(8'h3C);
    check_frame(8'h3C, 4, 2'b00, 1'b0, mlen, swait, par);
    checkOutput("midrst_new_len", mlen, 40);

    // Divisor change mid-frame only affects the following frame.
    wr_en = 1'b1;
    wr_data = 8'h96;
    @(negedge clk);
    wr_data = 8'h69;
    @(negedge clk);
    wr_en = 1'b0;
    fork
      begin
        check_frame(8'h96, 4, 2'b00, 1'b0, mlen, swait, par);
        checkOutput("cfg_len1", mlen, 40);
        check_frame(8'h69, 8, 2'b00, 1'b0, mlen, swait, par);
        checkOutput("cfg_len2", mlen, 80);
        checkOutput("cfg_gap", swait, 0);
      end
      begin
        repeat (12) @(negedge clk);
        baud_div = 16'd8;
      end
    join
    repeat (3) @(negedge clk);

    // Randomized batches against the queue model.
    for (int b = 0; b < 12; b++) begin
      rdiv = int'($urandom_range(0, 5));
      rpm  = 2'($urandom_range(0, 3));
      rs2  = 1'($urandom_range(0, 1));
      rn   = int'($urandom_range(1, 6));
      baud_div = 16'(rdiv);
      parity_mode = rpm;
      stop2 = rs2;
      q.delete();
      fork
        begin
          for (int i = 0; i < rn; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int w = 0; w < 10000 && !wr_ready; w++) @(negedge clk);
            pd = 8'($urandom);
            wr_data = pd;
            wr_en = 1'b1;
            q.push_back(pd);
            @(negedge clk);
            wr_en = 1'b0;
          end
        end
        begin
          for (int i = 0; i < rn; i++) begin
            for (int w = 0; w < 10000 && q.size() == 0; w++) @(negedge clk);
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("[TB] FAIL rand_queue_timeout: batch %0d frame %0d", b, i);
            end else begin
              cd = q.pop_front();
              check_frame(cd, eff_div(rdiv), rpm, rs2, mlen, swait, par);
              checkOutput($sformatf("rand_b%0d_f%0d_len", b, i), mlen,
                          frame_len(eff_div(rdiv), rpm, rs2));
            end
          end
        end
      join
      repeat (4) @(negedge clk);
      checkOutput($sformatf("rand_b%0d_idle_empty", b), fifo_empty, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the fixed 8N1 send path.
- Buffers bytes from a producer in a FIFO, then serialises them on TXD.
- Frame format is configurable:
  - data bits: 5..8, set by parameter
  - parity: none, even or odd
  - stop bits: 1 or 2
  - bit period: runtime divisor
- Sits between the LCD/HMI command builder and the pin. Streams frames back-to-back with no CPU pacing.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two, ≥2.
- DIV_W, 16, width of the baud divisor.
- CNT_W, 5, width of fifo_count; must be ≥ log2(FIFO_DEPTH)+1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- wr_data, input, DATA_BITS, byte to enqueue.
- wr_en, input, 1, enqueue strobe; accepted only when wr_ready=1.
- wr_ready, output, 1, FIFO not full.
- baud_div, input, DIV_W, clk cycles per bit.
- parity_mode, input, 2, 00=none, 01=even, 10=odd, 11=none.
- stop2, input, 1, 1 = two stop bits.
- ovf_clr, input, 1, clears overflow.
- txd, output, 1, serial out; idle high.
- tx_busy, output, 1, high while the FSM is not in IDLE.
- frame_done, output, 1, one-cycle pulse at the end of each frame.
- fifo_count, output, CNT_W, entries currently stored.
- fifo_empty, output, 1, fifo_count==0.
- overflow, output, 1, sticky: a write was attempted while full.

Behaviour:
- Reset values:
  - txd=1, tx_busy=0, frame_done=0, fifo_count=0, fifo_empty=1, wr_ready=1, overflow=0.
  - FIFO pointers are cleared; FSM goes to IDLE.
- Reset mid-frame:
  - txd returns to 1 at the next edge.
  - The partial frame and all FIFO contents are discarded.
  - No frame_done pulse is generated.
- FIFO:
  - Write occurs when wr_en && wr_ready.
  - wr_ready is registered, equal to !full.
  - A write while full is dropped and sets overflow. This holds even if a pop happens in the same cycle.
  - Simultaneous write and pop when not full leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ovf_clr clears overflow. If wr_en && full occur in the same cycle as ovf_clr, set wins.
- Config latch:
  - At each frame start the FSM latches baud_div, parity_mode and stop2.
  - Changes mid-frame have no effect on the current frame.
  - A latched baud_div below 2 is treated as 2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the FIFO is not empty: pop the head into the shift register, latch config, go to START.
  - Latency: a write sampled at edge N into an empty FIFO with FSM in IDLE gives txd=0 from edge N+2.
- START: txd=0 for div cycles, then go to DATA.
- DATA:
  - Sends DATA_BITS bits LSB-first, each for div cycles.
  - Then goes to PARITY if parity is enabled, otherwise to STOP.
- PARITY:
  - Even mode sends the XOR of the data bits.
  - Odd mode sends its inverse.
  - Lasts div cycles.
- STOP:
  - txd=1 for div cycles (1 stop) or 2·div cycles (2 stops).
  - frame_done pulses in the last cycle of STOP.
  - If the FIFO is not empty in that cycle: pop and go directly to START. The next start bit follows with zero idle cycles.
  - Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + P + S)·div cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Bit timing: a down-counter loaded with div−1 at each bit boundary; no drift.

Test Plan:
- Basic 8N1 frame:
  - Setup: baud_div=4, parity_mode=00, stop2=0; write 0x55.
  - txd: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles.
  - frame_done pulses once, 40 cycles after the start edge; tx_busy falls the next cycle.
- Parity:
  - Write 0x07 with even parity: parity bit = 1.
  - Same byte with odd parity: parity bit = 0.
  - Each frame is 44 cycles at div=4.
- Back-to-back with two stop bits:
  - Setup: stop2=1, write 0xA3 and 0x3C in consecutive cycles.
  - Two frames of 44 cycles each (div=4, no parity); the second start bit immediately follows the 8 stop cycles.
  - frame_done pulses twice.
- FIFO full and overflow:
  - Setup: FIFO_DEPTH=4, baud_div=100. Write 6 bytes 0x01..0x06 in 6 consecutive cycles.
  - The first byte is popped at once, so 0x01..0x05 are accepted; fifo_count peaks at 4 and wr_ready=0.
  - 0x06 is dropped and overflow=1. Exactly 5 frames are emitted.
  - ovf_clr clears overflow.
- Reset mid-frame:
  - Assert rst during the DATA bits with 3 bytes queued.
  - txd=1 next cycle, fifo_count=0, no further frames.
  - A new write afterwards transmits normally.
- Config change mid-frame and minimum divisor:
  - Change baud_div 4→8 during frame 1: frame 1 keeps 4-cycle bits; frame 2 uses 8-cycle bits.
  - baud_div=0 gives 2-cycle bits.
